// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
// Scan-code prefixes, movement key codes and the frame-state enum.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_D = 8'h23;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Decoded scan-code bus from the PS/2 receiver to keyboard consumers.
// master: receiver drives code, flags and strobes; slave: consumer reads.
interface ps2_keyboard_rx_if;

    logic [7:0] ps2_data;
    logic       received_data;
    logic       key_break;
    logic       key_extended;
    logic       frame_error;

    modport master (
        output ps2_data,
        output received_data,
        output key_break,
        output key_extended,
        output frame_error
    );

    modport slave (
        input ps2_data,
        input received_data,
        input key_break,
        input key_extended,
        input frame_error
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Pin synchronizers, ps2_clk glitch filter and falling-edge detector.
// Ports: clk, reset, ps2_clk/ps2_dat raw pins; clk_fall pulse, dat_sync.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_fall,
    output logic dat_sync
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic [CW-1:0]          flt_cnt_q, flt_cnt_d;
    logic                   filt_q, filt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            flt_cnt_q  <= '0;
            filt_q     <= 1'b1;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            flt_cnt_q  <= flt_cnt_d;
            filt_q     <= filt_d;
        end
    end

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
        flt_cnt_d  = '0;
        filt_d     = filt_q;
        // Count consecutive samples that disagree with the filtered level.
        if (clk_sync_q[SYNC_STAGES-1] != filt_q) begin
            if (flt_cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = ~filt_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
        clk_fall = filt_q & ~filt_d;
        dat_sync = dat_sync_q[SYNC_STAGES-1];
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: deframes, checks and decodes scan codes.
// Ports: clk, reset, ps2_clk, ps2_dat pins; rx bus (code, flags, strobes).
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ps2_clk,
    input  logic               ps2_dat,
    ps2_keyboard_rx_if.master  rx
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic sample;
    logic dat;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .clk_fall (sample),
        .dat_sync (dat)
    );

    frame_state_e state_q, state_d;
    logic [7:0]   shift_q, shift_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic         par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic         ext_pend_q, ext_pend_d;
    logic         brk_pend_q, brk_pend_d;
    logic [7:0]   data_q, data_d;
    logic         rx_q, rx_d;
    logic         kbrk_q, kbrk_d;
    logic         kext_q, kext_d;
    logic         err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            data_q     <= '0;
            rx_q       <= 1'b0;
            kbrk_q     <= 1'b0;
            kext_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            data_q     <= data_d;
            rx_q       <= rx_d;
            kbrk_q     <= kbrk_d;
            kext_q     <= kext_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        data_d     = data_q;
        rx_d       = 1'b0;
        kbrk_d     = kbrk_q;
        kext_d     = kext_q;
        err_d      = 1'b0;

        if (state_q == IDLE || sample) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (sample) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    // Odd parity over data plus parity bit, stop must be 1.
                    if (dat && (^{shift_q, par_q})) begin
                        if (shift_q == PS2_EXT) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == PS2_BRK) begin
                            brk_pend_d = 1'b1;
                        end else begin
                            data_d     = shift_q;
                            kbrk_d     = brk_pend_q;
                            kext_d     = ext_pend_q;
                            rx_d       = 1'b1;
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                        end
                    end else begin
                        err_d      = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d    = IDLE;
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
    end

    assign rx.ps2_data      = data_q;
    assign rx.received_data = rx_q;
    assign rx.key_break     = kbrk_q;
    assign rx.key_extended  = kext_q;
    assign rx.frame_error   = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx with a frame-level event model.
// Drives bit-banged PS/2 frames; checks strobes, flags, errors and latency.
module tb_ps2_keyboard_rx;

    localparam int SS  = 2;
    localparam int FL  = 8;
    localparam int TMO = 600;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk_r = 1'b1;
    logic ps2_dat_r = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    ps2_keyboard_rx_if rx_if ();

    ps2_keyboard_rx #(
        .SYNC_STAGES    (SS),
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ps2_clk (ps2_clk_r),
        .ps2_dat (ps2_dat_r),
        .rx      (rx_if.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        bit         err;
        logic [7:0] d;
        bit         b;
        bit         e;
        int         t0;
        bit         lat;
    } ev_t;

    ev_t        q[$];
    bit         pend_e = 0;
    bit         pend_b = 0;
    logic [7:0] m_data = 8'h00;
    bit         m_b = 0;
    bit         m_e = 0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Frame-level decode model: what one complete frame must produce.
    task automatic model_frame(logic [7:0] b, bit par, bit stp, int t0);
        ev_t ev;
        ev.t0 = t0;
        ev.lat = 1;
        ev.d = b;
        ev.b = 0;
        ev.e = 0;
        if (!(stp && ((^b) ^ par))) begin
            ev.err = 1;
            q.push_back(ev);
            pend_e = 0;
            pend_b = 0;
        end else if (b == 8'hE0) begin
            pend_e = 1;
        end else if (b == 8'hF0) begin
            pend_b = 1;
        end else begin
            ev.err = 0;
            ev.b = pend_b;
            ev.e = pend_e;
            q.push_back(ev);
            pend_e = 0;
            pend_b = 0;
        end
    endtask

    function automatic bit odd_par(logic [7:0] b);
        return ~^b;
    endfunction

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the first nbits of a frame; the model is told at the stop fall.
    task automatic send_bits(logic [7:0] b, bit par, bit stp, int nbits, int h);
        logic [10:0] fr;
        fr = {stp, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat_r = fr[i];
            wait_cyc(h);
            if (i == 10) model_frame(b, par, stp, cyc);
            ps2_clk_r = 1'b0;
            wait_cyc(h);
            ps2_clk_r = 1'b1;
        end
        wait_cyc(h);
        ps2_dat_r = 1'b1;
    endtask

    task automatic send(logic [7:0] b, int h = 40);
        send_bits(b, odd_par(b), 1'b1, 11, h);
    endtask

    task automatic drain(string nm, int limit);
        for (int i = 0; i < limit && q.size() != 0; i++) @(posedge clk);
        wait_cyc(2);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d expected events not seen", nm, q.size());
            q.delete();
        end
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_data"}, rx_if.ps2_data, 8'h00);
        chk({nm, "_rx"}, rx_if.received_data, 0);
        chk({nm, "_brk"}, rx_if.key_break, 0);
        chk({nm, "_ext"}, rx_if.key_extended, 0);
        chk({nm, "_err"}, rx_if.frame_error, 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_if.received_data || rx_if.frame_error) begin
                chk("exclusive", rx_if.received_data & rx_if.frame_error, 0);
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected: rx=%0b err=%0b data=%0h, expected none",
                             rx_if.received_data, rx_if.frame_error, rx_if.ps2_data);
                end else begin
                    ev_t ev;
                    int  lat;
                    ev = q.pop_front();
                    chk("kind_err", rx_if.frame_error, ev.err);
                    if (!ev.err) begin
                        chk("code", rx_if.ps2_data, ev.d);
                        chk("brk", rx_if.key_break, ev.b);
                        chk("ext", rx_if.key_extended, ev.e);
                        m_data = ev.d;
                        m_b = ev.b;
                        m_e = ev.e;
                    end
                    if (ev.lat) begin
                        lat = cyc - ev.t0;
                        n_cmp++;
                        if (lat < SS + FL || lat > SS + FL + 2) begin
                            n_bad++;
                            $display("FAIL latency: got %0d, expected %0d..%0d",
                                     lat, SS + FL, SS + FL + 2);
                        end
                    end
                end
            end
            chk("hold_data", rx_if.ps2_data, m_data);
            chk("hold_brk", rx_if.key_break, m_b);
            chk("hold_ext", rx_if.key_extended, m_e);
        end
    end

    initial begin
        ev_t ev;
        wait_cyc(3);
        chk_zero("reset");
        reset = 1'b0;
        wait_cyc(20);

        // 1: plain key
        send(8'h1D, 200);
        drain("t1", 100);
        chk("t1_code", rx_if.ps2_data, 8'h1D);
        chk("t1_brk", rx_if.key_break, 0);
        chk("t1_ext", rx_if.key_extended, 0);

        // 2: break prefix
        send(8'hF0);
        send(8'h1C);
        drain("t2", 100);
        chk("t2_code", rx_if.ps2_data, 8'h1C);
        chk("t2_brk", rx_if.key_break, 1);
        chk("t2_ext", rx_if.key_extended, 0);

        // 3: extended break, then plain
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        drain("t3a", 100);
        chk("t3_code", rx_if.ps2_data, 8'h75);
        chk("t3_brk", rx_if.key_break, 1);
        chk("t3_ext", rx_if.key_extended, 1);
        send(8'h23);
        drain("t3b", 100);
        chk("t3b_brk", rx_if.key_break, 0);
        chk("t3b_ext", rx_if.key_extended, 0);

        // 4: parity error, then good frame; also a stop-bit error
        send(8'hF0);
        send_bits(8'h23, 1'b1, 1'b1, 11, 40);
        send_bits(8'h44, odd_par(8'h44), 1'b0, 11, 40);
        drain("t4a", 100);
        chk("t4_hold", rx_if.ps2_data, 8'h23);
        send(8'h1B);
        drain("t4b", 100);
        chk("t4_code", rx_if.ps2_data, 8'h1B);
        chk("t4_brk", rx_if.key_break, 0);

        // 5: timeout mid-frame
        send(8'hE0);
        ev.err = 1; ev.d = 0; ev.b = 0; ev.e = 0; ev.t0 = 0; ev.lat = 0;
        q.push_back(ev);
        pend_e = 0;
        pend_b = 0;
        send_bits(8'h0F, 1'b0, 1'b1, 5, 40);
        wait_cyc(TMO + 10);
        drain("t5a", 200);
        send(8'h1C);
        drain("t5b", 100);
        chk("t5_code", rx_if.ps2_data, 8'h1C);
        chk("t5_ext", rx_if.key_extended, 0);

        // 6a: short clk glitch in idle, then a normal frame
        ps2_clk_r = 1'b0;
        wait_cyc(FL - 2);
        ps2_clk_r = 1'b1;
        wait_cyc(50);
        send(8'h1D);
        drain("t6a", 100);

        // 6b: reset mid-frame with an extended prefix pending
        send(8'hE0);
        send_bits(8'h2A, 1'b0, 1'b1, 7, 40);
        @(negedge clk);
        reset = 1'b1;
        pend_e = 0;
        pend_b = 0;
        m_data = 8'h00;
        m_b = 0;
        m_e = 0;
        q.delete();
        #1;
        chk_zero("t6_rst");
        ps2_dat_r = 1'b1;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(20);
        send(8'h1D);
        drain("t6b", 100);
        chk("t6_code", rx_if.ps2_data, 8'h1D);
        chk("t6_ext", rx_if.key_extended, 0);

        // randomized frames with occasional corruption
        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            bit         p;
            bit         s;
            int         h;
            int         r;
            r = int'($urandom_range(0, 5));
            if (r == 0) b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else b = 8'($urandom_range(0, 255));
            p = odd_par(b);
            if ($urandom_range(0, 7) == 0) p = ~p;
            s = ($urandom_range(0, 9) != 0);
            h = int'($urandom_range(20, 60));
            send_bits(b, p, s, 11, h);
        end
        drain("rand", 200);
        wait_cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 device-to-host receiver that produces the scan-code byte stream for the player movement FSM and any other keyboard consumers.
- Samples the raw PS/2 clock/data pins, deframes 11-bit frames, checks start/parity/stop and enforces an inter-edge timeout.
- Folds 0xE0 (extended) and 0xF0 (break) prefixes into flags.
- Emits one strobed code per key event on ps2_data / received_data.

Parameters:
SYNC_STAGES, 2, flip-flops in each pin synchronizer (min 2)
FILTER_LEN, 8, consecutive equal clk samples required before the filtered ps2_clk changes
TIMEOUT_CYCLES, 50000, clk cycles allowed between ps2_clk falling edges inside a frame (1 ms at 50 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_dat  in  1  raw PS/2 data pin, asynchronous
ps2_data  out  8  last decoded scan code; held until the next valid code
received_data  out  1  one-cycle strobe: ps2_data, key_break and key_extended valid
key_break  out  1  code was preceded by 0xF0 (key release)
key_extended  out  1  code was preceded by 0xE0
frame_error  out  1  one-cycle strobe on parity, stop or timeout failure

Behaviour:
- Reset (async, active-high):
  - State IDLE; filtered clk = 1; all synchronizer flops = 1.
  - Shift register, bit count, timeout counter and pending flags cleared.
  - All outputs 0.
  - Reset mid-frame discards the partial frame; the first full frame after reset release decodes normally.
- Line filter:
  - Both pins pass through SYNC_STAGES flops.
  - Filtered clk toggles only after FILTER_LEN consecutive synchronized samples differ from its current value.
  - A sample point is a 1->0 transition of filtered clk.
  - ps2_dat (synchronized only) is sampled in the cycle of that transition.
- Frame FSM, advancing only on sample points:
  - IDLE: dat=0 -> DATA with bit count 0; dat=1 -> stay IDLE (no error).
  - DATA: shift dat in LSB-first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: frame OK iff dat=1 and XOR(data[7:0], parity)=1 (odd parity); -> IDLE either way.
- Timeout:
  - Counter clears on every sample point and is held at 0 in IDLE.
  - In any state other than IDLE, reaching TIMEOUT_CYCLES-1 -> IDLE with a frame_error pulse.
- Frame failure (parity, stop or timeout):
  - frame_error=1 for exactly one cycle.
  - Both pending flags cleared; ps2_data unchanged; no received_data.
- Decode on a good frame:
  - byte 0xE0: set ext_pending; no strobe.
  - byte 0xF0: set brk_pending; no strobe.
  - Any other byte:
    - In the cycle after the STOP sample point: ps2_data=byte, key_extended=ext_pending, key_break=brk_pending, received_data=1 for one cycle.
    - Both pending flags then clear.
    - key_break and key_extended hold until the next strobe.
- Latency: from the pin falling edge of the stop-bit clock to received_data is SYNC_STAGES+FILTER_LEN+1 cycles, ±1.
- A new frame may start on the sample point immediately after STOP; no dead time is required.
- received_data and frame_error are never asserted in the same cycle.
- No host-to-device transmission; the pins are inputs only.

Decomposition:
- Shared package ps2_pkg:
  - Constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0.
  - Movement codes: KEY_W=8'h1D, KEY_A=8'h1C, KEY_S=8'h1B, KEY_D=8'h23.
  - Frame-state enum {IDLE, DATA, PARITY, STOP}.
- Sub-module ps2_line_filter: synchronizer, FILTER_LEN glitch filter, falling-edge pulse, synchronized data out.
  - Instantiated once; it handles both pins.

Test Plan:
1. Frame 0x1D (parity 1, stop 1) at 12.5 kHz PS/2 clock -> exactly one received_data pulse; ps2_data=8'h1D, key_break=0, key_extended=0; no frame_error.
2. Frames 0xF0, then 0x1C -> no strobe after 0xF0; one strobe with ps2_data=8'h1C, key_break=1, key_extended=0.
3. Frames 0xE0, 0xF0, 0x75 (parity 0) -> single strobe with ps2_data=8'h75, key_extended=1, key_break=1; a following plain 0x23 frame strobes with both flags 0.
4. 0x23 sent with parity=1 (wrong), then a correct 0x1B -> frame_error pulse, no strobe, ps2_data stays at its prior value; then a strobe with ps2_data=8'h1B.
5. Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES+10 -> one frame_error pulse and FSM in IDLE; the next full 0x1C frame decodes correctly.
6. Noise and reset:
   - ps2_clk low glitch of FILTER_LEN-2 cycles in IDLE -> no state change, no outputs.
   - Reset asserted after 6 data bits -> all outputs 0 at once; after release, a full 0x1D frame strobes correctly.
